shared_var_arbiter: RTL and testbench
=====================================

// Module: shared_var_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer for a single shared variable register accessed by
//   NUM_REQ requesters (module-side agents or interface-bound programs).
//   Serialises read, post-increment, post-decrement and write ops; returns pre-op value.
//   Sits between the requesters and the shared-state register inside a common interface.
// PARAMETERS
//   NUM_REQ   4    number of requesters, >=2
//   DATA_W    32   width of shared variable
//   INIT_VAL  0    value of shared variable after reset
// PORTS
//   clk         in   1              clock, all state on rising edge
//   rst         in   1              asynchronous reset, active-high
//   req         in   NUM_REQ        per-requester access request, level
//   req_op      in   2*NUM_REQ      op for requester i at [2i+1:2i]: 00 READ, 01 INC, 10 WRITE, 11 DEC
//   req_wdata   in   DATA_W*NUM_REQ write data for requester i at [DATA_W*i +: DATA_W]
//   gnt         out  NUM_REQ        one-hot grant, one-cycle pulse
//   rsp_valid   out  1              response strobe, one cycle
//   rsp_id      out  $clog2(NUM_REQ) index of requester being answered
//   rsp_data    out  DATA_W         shared value before the op
//   shared_val  out  DATA_W         current shared value (registered)
//   wrap        out  1              one-cycle pulse: INC from all-ones or DEC from zero
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0,
//     wrap=0, shared_val=INIT_VAL, rr pointer=0 (requester 0 highest priority).
//   FSM, two states:
//     IDLE: if any req, select winner = first set req at or after rr pointer (circular);
//       at clock edge latch winner idx, its op and wdata, set gnt[winner]=1, go BUSY.
//       No req -> stay IDLE, gnt=0.
//     BUSY: gnt[winner] high this cycle only. At clock edge: perform op on shared_val,
//       rsp_valid=1, rsp_id=winner, rsp_data=old shared_val, rr pointer=winner+1 mod
//       NUM_REQ, gnt=0, go IDLE.
//   Ops: READ no change; INC +1 mod 2^DATA_W; DEC -1 mod 2^DATA_W; WRITE loads wdata.
//   wrap pulses with rsp_valid when INC on all-ones (->0) or DEC on 0 (->all-ones).
//   Latency: req seen in IDLE cycle N -> gnt in N+1 -> rsp_valid and new shared_val in N+2.
//   Throughput: one op per 2 cycles; rsp cycle overlaps next IDLE arbitration.
//   op/wdata sampled only at IDLE->BUSY edge; req drop or op change during BUSY ignored.
//   Requester holds req until it sees its gnt; req still high after gnt = new request,
//     competes again with lowest priority (round robin, no starvation: max wait NUM_REQ ops).
//   rsp_valid, rsp_id, rsp_data, wrap hold 0/last cleared value when no response:
//     rsp_valid=0 and wrap=0 every non-response cycle; rsp_id/rsp_data hold last value.
//   Reset asserted mid-BUSY: op discarded, no rsp, shared_val=INIT_VAL.
//   req bits >= NUM_REQ do not exist; no X propagation: unknown op impossible (2-bit full decode).
// TESTING
//   Reset with INIT_VAL=0 -> gnt=0, rsp_valid=0, shared_val=0, wrap=0 for 5 idle cycles.
//   req[1]=1 op INC, shared=5 -> gnt=4'b0010 at N+1; rsp_valid, rsp_id=1, rsp_data=5,
//     shared_val=6 at N+2.
//   req=4'b1111 all INC from 0, held 8 ops -> grant order 0,1,2,3,0,1,2,3; rsp_data 0..7;
//     gnt never 2 cycles consecutive.
//   shared=32'hFFFF_FFFF, req[2] INC -> rsp_data=FFFF_FFFF, shared_val=0, wrap=1 one cycle;
//     then DEC -> shared_val=FFFF_FFFF, wrap=1.
//   req[3] WRITE 0xA5 then req[0] READ -> rsp_data old then 0xA5; shared stays 0xA5 after READ.
//   rst pulsed in BUSY of a WRITE 0x33 -> no rsp_valid, shared_val=INIT_VAL, next grant to req 0.

Source files
------------

// File: rtl/shared_var_arbiter.sv
// Round-robin sequencer for one shared variable register.
// Serialises READ/INC/WRITE/DEC ops and returns the pre-op value.
module shared_var_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [DATA_W-1:0]          shared_val,
  output logic                       wrap
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_DEC   = 2'b11;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [1:0]         op_q, op_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [DATA_W-1:0]  shared_q, shared_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               wrap_q, wrap_d;

  logic               found;
  logic [IDX_W-1:0]   win_sel;

  // Circular index base+k, wrapped at NUM_REQ (NUM_REQ need not be a power of 2).
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Pick the first active request at or after the round-robin pointer.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[rr_idx(rr_q, k)]) begin
        found   = 1'b1;
        win_sel = rr_idx(rr_q, k);
      end
    end
  end

  // Next-state, op execution and response generation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    win_d       = win_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    rr_d        = rr_q;
    shared_d    = shared_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    wrap_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = BUSY;
          gnt_d[win_sel] = 1'b1;
          win_d          = win_sel;
          op_d           = req_op[2*win_sel +: 2];
          wdata_d        = req_wdata[DATA_W*win_sel +: DATA_W];
        end
      end
      BUSY: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = win_q;
        rsp_data_d  = shared_q;
        rr_d        = rr_idx(win_q, 1);
        unique case (op_q)
          OP_READ:  shared_d = shared_q;
          OP_INC: begin
            shared_d = shared_q + DATA_W'(1);
            wrap_d   = (shared_q == '1);
          end
          OP_WRITE: shared_d = wdata_q;
          OP_DEC: begin
            shared_d = shared_q - DATA_W'(1);
            wrap_d   = (shared_q == '0);
          end
        endcase
      end
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      win_q       <= '0;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      rr_q        <= '0;
      shared_q    <= INIT_VAL;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      win_q       <= win_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      rr_q        <= rr_d;
      shared_q    <= shared_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      wrap_q      <= wrap_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign shared_val = shared_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_shared_var_arbiter.sv
// Directed bench for shared_var_arbiter: op table plus
// round-robin and reset-in-BUSY sequences.
module tb_shared_var_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [7:0]   req_op;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic [31:0]  shared_val;
  logic         wrap;

  int n_vec = 0;
  int n_err = 0;

  shared_var_arbiter #(.NUM_REQ(4), .DATA_W(32), .INIT_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .shared_val(shared_val),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [31:0] e_data;
    logic [31:0] e_sh;
    logic        e_wrap;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int id);
    logic [3:0] one;
    one = 4'd1;
    return one << id;
  endfunction

  // Single-requester transaction: request, wait for grant, drop req.
  task automatic issue(input int id, input logic [1:0] op,
                       input logic [31:0] wd);
    bit got;
    got = 0;
    @(negedge clk);
    req = oh(id);
    req_op[2*id +: 2] = op;
    req_wdata[32*id +: 32] = wd;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (gnt != 4'b0) got = 1;
    end
    chk("gnt", 64'(gnt), 64'(oh(id)));
    req = 4'b0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{3, 2'b10, 32'h5,        32'h0,        32'h5,        1'b0};
    tbl[1] = '{1, 2'b01, 32'h0,        32'h5,        32'h6,        1'b0};
    tbl[2] = '{2, 2'b10, 32'hFFFFFFFF, 32'h6,        32'hFFFFFFFF, 1'b0};
    tbl[3] = '{2, 2'b01, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[4] = '{2, 2'b11, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1};
    tbl[5] = '{0, 2'b11, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    tbl[6] = '{3, 2'b10, 32'hA5,       32'hFFFFFFFE, 32'hA5,       1'b0};
    tbl[7] = '{0, 2'b00, 32'h0,        32'hA5,       32'hA5,       1'b0};
    tbl[8] = '{1, 2'b00, 32'h0,        32'hA5,       32'hA5,       1'b0};

    rst = 1'b1;
    req = '0;
    req_op = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state over 5 idle cycles.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_shared", 64'(shared_val), 64'h0);
      chk("rst_wrap", 64'(wrap), 64'h0);
    end
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);

    // Table-driven single-op vectors.
    for (int v = 0; v < 9; v++) begin
      issue(tbl[v].id, tbl[v].op, tbl[v].wd);
      chk("rsp_valid", 64'(rsp_valid), 64'h1);
      chk("rsp_id", 64'(rsp_id), 64'(tbl[v].id));
      chk("rsp_data", 64'(rsp_data), 64'(tbl[v].e_data));
      chk("shared_val", 64'(shared_val), 64'(tbl[v].e_sh));
      chk("wrap", 64'(wrap), 64'(tbl[v].e_wrap));
      @(negedge clk);
      chk("rsp_clr", 64'(rsp_valid), 64'h0);
      chk("wrap_clr", 64'(wrap), 64'h0);
      chk("rsp_data_hold", 64'(rsp_data), 64'(tbl[v].e_data));
    end

    // Round robin: all four requesters INC from 0, held for 8 ops.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int n_g, n_r;
      logic [3:0] prev_g;
      n_g = 0;
      n_r = 0;
      prev_g = '0;
      req_op = 8'b01_01_01_01;
      req = 4'b1111;
      for (int c = 0; c < 40 && n_r < 8; c++) begin
        @(negedge clk);
        if (gnt != 4'b0) begin
          chk("rr_gnt", 64'(gnt), 64'(oh(n_g % 4)));
          chk("rr_gnt_gap", 64'(prev_g), 64'h0);
          n_g++;
        end
        if (rsp_valid) begin
          chk("rr_rsp_id", 64'(rsp_id), 64'(n_r % 4));
          chk("rr_rsp_data", 64'(rsp_data), 64'(n_r));
          n_r++;
          if (n_r == 8) req = 4'b0;
        end
        prev_g = gnt;
      end
      chk("rr_rsp_count", 64'(n_r), 64'd8);
      @(negedge clk);
      chk("rr_final_shared", 64'(shared_val), 64'd8);
      chk("rr_no_extra_gnt", 64'(gnt), 64'h0);
    end

    // Reset during BUSY of a WRITE: op lost, pointer back to 0.
    issue(1, 2'b00, 32'h0);
    @(negedge clk);
    req = 4'b1000;
    req_op[7:6] = 2'b10;
    req_wdata[127:96] = 32'h33;
    @(negedge clk);
    chk("busy_gnt", 64'(gnt), 64'h8);
    req = 4'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstb_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rstb_shared", 64'(shared_val), 64'h0);
    end
    req_op = 8'b00_00_00_00;
    req = 4'b1001;
    @(negedge clk);
    chk("rstb_next_gnt", 64'(gnt), 64'h1);
    req = 4'b0;
    @(negedge clk);
    chk("rstb_rsp_id", 64'(rsp_id), 64'h0);
    chk("rstb_rsp_data", 64'(rsp_data), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
